// File: rtl/pipe_buffer_chain.sv
// pipe_buffer_chain: STAGES-deep chain of WIDTH-bit pipeline registers with
// valid/ready backpressure, bubble collapsing and a per-stage flush.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready/in_data    upstream handshake into stage 0
//   flush[STAGES]           flush[k] drops the stage-k content at the edge
//   out_valid/out_ready/out_data downstream handshake from stage STAGES-1
//   occupancy               number of valid stages (combinational from state)
//   stall_cnt, bubble_cnt   saturating perf counters, only when the macro
//                           PIPE_BUFFER_CHAIN_PERF_EN is defined
//
// in_ready and occupancy are combinational from the stage valids; the payload
// and valid bits themselves are all registered.
module pipe_buffer_chain #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [STAGES-1:0]            flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
`ifdef PIPE_BUFFER_CHAIN_PERF_EN
  output logic [31:0]                  stall_cnt,
  output logic [31:0]                  bubble_cnt,
`endif
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int unsigned OCC_W = $clog2(STAGES + 1);

  if (STAGES < 1) begin : g_bad_stages
    $error("pipe_buffer_chain: STAGES must be >= 1");
  end

  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  d     [STAGES];
  logic              src_v [STAGES];
  logic [WIDTH-1:0]  src_d [STAGES];
  logic [STAGES:0]   rdy;

  // Source of each stage: the input port for stage 0, the previous stage otherwise.
  for (genvar k = 0; k < STAGES; k++) begin : g_src
    if (k == 0) begin : g_head
      assign src_v[k] = in_valid;
      assign src_d[k] = in_data;
    end else begin : g_body
      assign src_v[k] = v[k-1];
      assign src_d[k] = d[k-1];
    end
  end

  // Ready chain: a stage can load if it is empty or anything downstream of it
  // is empty/draining; an accumulator avoids a self-referencing vector.
  always_comb begin
    logic acc;
    acc = out_ready;
    rdy = '0;
    rdy[STAGES] = acc;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      acc    = acc | ~v[k];
      rdy[k] = acc;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];

  // Stage registers; flush wins over load/hold, data only moves with a valid item.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < int'(STAGES); k++) d[k] <= '0;
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (flush[k])    v[k] <= 1'b0;
        else if (rdy[k]) v[k] <= src_v[k];
        if (rdy[k] && src_v[k]) d[k] <= src_d[k];
      end
    end
  end

  // Population count of the valid bits.
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      occupancy = occupancy + OCC_W'(v[k]);
    end
  end

`ifdef PIPE_BUFFER_CHAIN_PERF_EN
  // Saturating stall / bubble counters observed at the output port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (out_ready && !out_valid && bubble_cnt != 32'hFFFF_FFFF)
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule
